// File: rtl/ssd_pkg.sv
// ssd_pkg: segment codes, converter state encoding and decode helper for the display driver
package ssd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'b1111;
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    return d == 4'd0 ? SEG_0 : d == 4'd1 ? SEG_1 : d == 4'd2 ? SEG_2 :
           d == 4'd3 ? SEG_3 : d == 4'd4 ? SEG_4 : d == 4'd5 ? SEG_5 :
           d == 4'd6 ? SEG_6 : d == 4'd7 ? SEG_7 : d == 4'd8 ? SEG_8 :
           d == 4'd9 ? SEG_9 : SEG_BLANK;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to 4-digit BCD converter, free-running
import ssd_pkg::*;
module bin2bcd_seq #(
  parameter int IN_W = 13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] value,
  output logic            busy,
  output logic            done,
  output logic [15:0]     bcd
);
  localparam int CW = $clog2(IN_W + 1);
  state_t state;
  logic [IN_W-1:0] bin;
  logic [15:0] acc;
  logic [15:0] adj;
  logic [CW-1:0] cnt;
  // nibble-local correction, no carry crosses a digit boundary
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bin <= '0;
      acc <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      bcd <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          bin <= value;
          acc <= '0;
          cnt <= CW'(IN_W);
          busy <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          {acc, bin} <= {adj, bin} << 1;
          cnt <= cnt - 1'b1;
          state <= cnt == CW'(1) ? COMMIT : SHIFT;
        end
        COMMIT: begin
          bcd <= acc;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ssd_display_driver.sv
// ssd_display_driver: binary value to multiplexed common-anode 4-digit seven-segment display
import ssd_pkg::*;
module ssd_display_driver #(
  parameter int IN_W      = 13,
  parameter int REFRESH_W = 18,
  parameter bit BLANK_LZ  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] value,
  output logic            busy,
  output logic            conv_done,
  output logic [3:0]      anode,
  output logic [6:0]      seg
);
  logic [15:0] digits;
  logic [REFRESH_W-1:0] ctr;
  logic [1:0] sel;
  logic [3:0] blank;
  logic [3:0] dig;
  bin2bcd_seq #(.IN_W(IN_W)) u_conv (
    .clk(clk),
    .rst(rst),
    .value(value),
    .busy(busy),
    .done(conv_done),
    .bcd(digits)
  );
  assign sel = ctr[REFRESH_W-1 -: 2];
  assign dig = digits[4*sel +: 4];
  // a digit blanks only when it and every higher digit are zero; digit0 always shows
  assign blank[3] = BLANK_LZ && digits[15:12] == 4'd0;
  assign blank[2] = blank[3] && digits[11:8] == 4'd0;
  assign blank[1] = blank[2] && digits[7:4] == 4'd0;
  assign blank[0] = 1'b0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr <= '0;
      anode <= ANODE_OFF;
      seg <= SEG_BLANK;
    end else begin
      ctr <= ctr + 1'b1;
      anode <= ~(4'b0001 << sel);
      seg <= blank[sel] ? SEG_BLANK : seg_decode(dig);
    end
  end
endmodule

// File: tb/tb_ssd_display_driver.sv
// tb_ssd_display_driver: directed checks of conversion timing, scan order, decode and blanking
module tb_ssd_display_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [12:0] value = 13'd1234;
  logic [12:0] value2 = 13'd7;
  logic busy, conv_done, busy2, conv_done2;
  logic [3:0] anode, anode2;
  logic [6:0] seg, seg2;
  int checks = 0;
  int errors = 0;
  logic [6:0] segs [4];
  logic [3:0] seen;

  always #5 clk = ~clk;

  ssd_display_driver #(.IN_W(13), .REFRESH_W(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .value(value), .busy(busy), .conv_done(conv_done),
    .anode(anode), .seg(seg)
  );
  ssd_display_driver #(.IN_W(13), .REFRESH_W(4), .BLANK_LZ(1'b0)) dut2 (
    .clk(clk), .rst(rst), .value(value2), .busy(busy2), .conv_done(conv_done2),
    .anode(anode2), .seg(seg2)
  );

  task automatic wait_done(input bit which);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      got = which ? conv_done2 : conv_done;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wait_done dut%0d: conv_done=0 after 40 cycles, expected a pulse", which + 1);
    end
  endtask

  task automatic scan(input bit which);
    logic [3:0] a;
    logic [6:0] s;
    logic [3:0] one_hot;
    seen = 4'h0;
    repeat (14) begin
      @(posedge clk); #1;
      a = which ? anode2 : anode;
      s = which ? seg2 : seg;
      for (int k = 0; k < 4; k++) begin
        one_hot = 4'b0001 << k;
        if (a == ~one_hot) begin
          segs[k] = s;
          seen[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset;
    logic [3:0] one_hot;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (anode !== 4'b1111) begin errors++; $display("FAIL reset_anode got=%b exp=1111", anode); end
    if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=7f", seg); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (conv_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", conv_done); end
    @(negedge clk) rst = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n <= 16) begin
        one_hot = 4'b0001 << ((n - 1) / 4);
        checks++;
        if (anode !== ~one_hot) begin
          errors++;
          $display("FAIL scan_order edge%0d anode got=%b exp=%b", n, anode, ~one_hot);
        end
      end
      if (n == 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_start got=%b exp=1", busy); end
      end
      checks++;
      if (conv_done !== (n == 15)) begin
        errors++;
        $display("FAIL first_commit edge%0d conv_done got=%b exp=%b", n, conv_done, n == 15);
      end
    end
  endtask

  task automatic test_digits;
    logic [6:0] e [4];
    e = '{7'h19, 7'h30, 7'h24, 7'h79};
    wait_done(1'b0);
    scan(1'b0);
    checks++;
    if (seen !== 4'hF) begin errors++; $display("FAIL digits_1234 seen got=%b exp=1111", seen); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (segs[k] !== e[k]) begin errors++; $display("FAIL digits_1234 d%0d seg got=%h exp=%h", k, segs[k], e[k]); end
    end
  endtask

  task automatic test_max_zero;
    logic [6:0] e [4];
    value = 13'd8191;
    wait_done(1'b0);
    wait_done(1'b0);
    scan(1'b0);
    e = '{7'h79, 7'h10, 7'h79, 7'h00};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (segs[k] !== e[k]) begin errors++; $display("FAIL digits_8191 d%0d seg got=%h exp=%h", k, segs[k], e[k]); end
    end
    value = 13'd0;
    wait_done(1'b0);
    wait_done(1'b0);
    scan(1'b0);
    e = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (segs[k] !== e[k]) begin errors++; $display("FAIL digits_0 d%0d seg got=%h exp=%h", k, segs[k], e[k]); end
    end
  endtask

  task automatic test_mid_change;
    logic [6:0] e [4];
    value = 13'd1234;
    wait_done(1'b0);
    repeat (3) @(posedge clk);
    #1 value = 13'd42;
    wait_done(1'b0);
    scan(1'b0);
    e = '{7'h19, 7'h30, 7'h24, 7'h79};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (segs[k] !== e[k]) begin errors++; $display("FAIL mid_change_first d%0d seg got=%h exp=%h", k, segs[k], e[k]); end
    end
    wait_done(1'b0);
    scan(1'b0);
    e = '{7'h24, 7'h19, 7'h7F, 7'h7F};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (segs[k] !== e[k]) begin errors++; $display("FAIL mid_change_second d%0d seg got=%h exp=%h", k, segs[k], e[k]); end
    end
  endtask

  task automatic test_async_reset;
    wait_done(1'b0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (anode !== 4'b1111) begin errors++; $display("FAIL async_anode got=%b exp=1111", anode); end
    if (seg !== 7'h7F) begin errors++; $display("FAIL async_seg got=%h exp=7f", seg); end
    if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got=%b exp=0", busy); end
    if (conv_done !== 1'b0) begin errors++; $display("FAIL async_done got=%b exp=0", conv_done); end
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (conv_done !== 1'b0 || anode !== 4'b1111) begin
        errors++;
        $display("FAIL async_hold conv_done=%b anode=%b exp 0/1111", conv_done, anode);
      end
    end
    @(negedge clk) rst = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      checks++;
      if (conv_done !== (n == 15)) begin
        errors++;
        $display("FAIL async_recommit edge%0d conv_done got=%b exp=%b", n, conv_done, n == 15);
      end
    end
  endtask

  task automatic test_blank_off;
    logic [6:0] e [4];
    e = '{7'h78, 7'h40, 7'h40, 7'h40};
    wait_done(1'b1);
    scan(1'b1);
    checks++;
    if (seen !== 4'hF) begin errors++; $display("FAIL blank_off seen got=%b exp=1111", seen); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (segs[k] !== e[k]) begin errors++; $display("FAIL blank_off d%0d seg got=%h exp=%h", k, segs[k], e[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_max_zero();
    test_mid_change();
    test_async_reset();
    test_blank_off();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
